ah_snoop_fifo_arbiter: RTL and testbench

AH_SNOOP_FIFO_ARBITER -- requirements
Module: ah_snoop_fifo_arbiter

---
 rtl/ah_snoop_fifo_arbiter.sv | 150 +++++++++++++++
 tb/tb_ah_snoop_fifo_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ah_snoop_fifo_arbiter.sv
// Round-robin write arbiter in front of a FIFO. Each granted payload is first
// snooped against the FIFO; matches are dropped and counted, others are written.
module ah_snoop_fifo_arbiter #(
  parameter int DW   = 110,
  parameter int NREQ = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    req_dup,
  output logic [DW-1:0]      fifo_wdata,
  output logic               fifo_wvalid,
  input  logic               fifo_wready,
  output logic [DW-1:0]      fifo_sdata,
  output logic               fifo_svalid,
  input  logic               fifo_smatch,
  output logic               busy,
  output logic [15:0]        dup_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SNOOP,
    ST_WAIT,
    ST_WRITE
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [IW-1:0] r_gnt;
  logic [IW-1:0] r_last;
  logic [DW-1:0] r_data;
  logic [15:0]   r_dup_cnt;

  logic [IW-1:0] w_pick;
  logic          w_found;
  logic [CW-1:0] w_cand;
  logic          w_take;
  logic          w_ack;
  logic          w_ack_dup;
  logic          w_svalid;
  logic          w_wvalid;
  logic [DW-1:0] w_req_data [NREQ];
  logic [NREQ-1:0] w_gnt_oh;

  // Per-requester views of the flat payload bus and of the acknowledge pulses.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign w_req_data[gi] = req_data[gi*DW +: DW];
    assign w_gnt_oh[gi]   = (r_gnt == IW'(gi));
    assign req_ready[gi]  = w_ack & w_gnt_oh[gi];
    assign req_dup[gi]    = w_ack_dup & w_gnt_oh[gi];
  end

  // Search starts one past the last acknowledged requester and wraps.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = CW'(r_last) + CW'(k);
      if (w_cand >= CW'(NREQ)) begin
        w_cand = w_cand - CW'(NREQ);
      end
      if (!w_found && req_valid[w_cand[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_ack        = 1'b0;
    w_ack_dup    = 1'b0;
    w_svalid     = 1'b0;
    w_wvalid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_take       = 1'b1;
          w_state_next = ST_SNOOP;
        end
      end
      ST_SNOOP: begin
        w_svalid     = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (fifo_smatch) begin
          w_ack        = 1'b1;
          w_ack_dup    = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_wvalid = 1'b1;
        if (fifo_wready) begin
          w_ack        = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Payload is captured at grant so requester changes cannot disturb the transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_gnt     <= '0;
      r_last    <= IW'(NREQ - 1);
      r_data    <= '0;
      r_dup_cnt <= '0;
    end else begin
      if (w_take) begin
        r_gnt  <= w_pick;
        r_data <= w_req_data[w_pick];
      end
      if (w_ack) begin
        r_last <= r_gnt;
      end
      if (w_ack_dup && (r_dup_cnt != 16'hFFFF)) begin
        r_dup_cnt <= r_dup_cnt + 16'd1;
      end
    end
  end

  assign fifo_sdata  = r_data;
  assign fifo_wdata  = r_data;
  assign fifo_svalid = w_svalid;
  assign fifo_wvalid = w_wvalid;
  assign busy        = (r_state != ST_IDLE);
  assign dup_cnt     = r_dup_cnt;

endmodule

// File: tb/tb_ah_snoop_fifo_arbiter.sv
// Scoreboard bench for ah_snoop_fifo_arbiter: a round-robin/FIFO-content model
// predicts every acknowledge; a monitor checks the DUT outputs against it.
module tb_ah_snoop_fifo_arbiter;
  localparam int DW   = 110;
  localparam int NREQ = 4;
  localparam int PMAX = 8;

  logic               clk = 1'b0;
  logic               rstn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_dup;
  logic [DW-1:0]      fifo_wdata;
  logic               fifo_wvalid;
  logic               fifo_wready;
  logic [DW-1:0]      fifo_sdata;
  logic               fifo_svalid;
  logic               fifo_smatch;
  logic               busy;
  logic [15:0]        dup_cnt;

  ah_snoop_fifo_arbiter #(.DW(DW), .NREQ(NREQ)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .req_dup(req_dup),
    .fifo_wdata(fifo_wdata), .fifo_wvalid(fifo_wvalid), .fifo_wready(fifo_wready),
    .fifo_sdata(fifo_sdata), .fifo_svalid(fifo_svalid), .fifo_smatch(fifo_smatch),
    .busy(busy), .dup_cnt(dup_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    bit            dup;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_fifo[$];
  logic [DW-1:0] rsp_fifo[$];
  int            model_last;
  logic [DW-1:0] pend_mem [NREQ][PMAX];
  int            pend_head [NREQ];
  int            pend_cnt [NREQ];
  bit            mon_en = 1'b0;
  logic [15:0]   mon_dup_exp;
  int            wr_mode = 1;
  int            ack_cyc_q[$];
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mk_uniq(input int n);
    logic [DW-1:0] v;
    v = '0;
    v[DW-1 -: 32] = 32'hC0DE0000 + 32'(n);
    return v;
  endfunction

  function automatic bit model_has(input logic [DW-1:0] v);
    foreach (model_fifo[i]) if (model_fifo[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pend_total();
    int s = 0;
    for (int i = 0; i < NREQ; i++) s += pend_cnt[i];
    return s;
  endfunction

  task automatic pend_push(input int i, input logic [DW-1:0] v);
    if (pend_cnt[i] == 0) pend_head[i] = 0;
    pend_mem[i][pend_head[i] + pend_cnt[i]] = v;
    pend_cnt[i]++;
  endtask

  // Reference model: serve queued payloads round-robin from the last grant;
  // a payload is a duplicate iff an equal word has already been written.
  task automatic plan_round();
    int lhead [NREQ];
    int lcnt [NREQ];
    int cur;
    int left;
    bit found;
    exp_t e;
    cur  = model_last;
    left = 0;
    for (int i = 0; i < NREQ; i++) begin
      lhead[i] = pend_head[i];
      lcnt[i]  = pend_cnt[i];
      left    += pend_cnt[i];
    end
    while (left > 0) begin
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        if (!found && lcnt[(cur + k) % NREQ] > 0) begin
          found = 1'b1;
          cur   = (cur + k) % NREQ;
        end
      end
      e.idx  = cur;
      e.data = pend_mem[cur][lhead[cur]];
      e.dup  = model_has(e.data);
      if (!e.dup) model_fifo.push_back(e.data);
      exp_q.push_back(e);
      lhead[cur]++;
      lcnt[cur]--;
      left--;
    end
    model_last = cur;
  endtask

  task automatic start_round();
    for (int i = 0; i < NREQ; i++) begin
      if (pend_cnt[i] > 0) begin
        req_data[i*DW +: DW] = pend_mem[i][pend_head[i]];
        req_valid[i] = 1'b1;
      end
    end
    plan_round();
  endtask

  task automatic wait_idle(input string name);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      done = (exp_q.size() == 0) && !busy && (pend_total() == 0);
    end
    chk({name, "_complete"}, done, 1);
    if (!done) begin
      exp_q.delete();
      req_valid = '0;
      for (int i = 0; i < NREQ; i++) pend_cnt[i] = 0;
    end
  endtask

  // Requester driver: on its acknowledge, a requester presents its next payload or drops valid.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && pend_cnt[i] > 0) begin
          pend_head[i]++;
          pend_cnt[i]--;
          if (pend_cnt[i] > 0) req_data[i*DW +: DW] = pend_mem[i][pend_head[i]];
          else req_valid[i] = 1'b0;
        end
      end
    end
  end

  // FIFO responder: answers snoops from its own record of accepted writes.
  initial begin
    bit hold;
    bit m;
    int lowc;
    hold = 1'b0;
    lowc = 0;
    fifo_smatch = 1'b0;
    fifo_wready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (fifo_svalid) begin
        m = 1'b0;
        foreach (rsp_fifo[i]) if (rsp_fifo[i] == fifo_sdata) m = 1'b1;
        fifo_smatch = m;
        hold = 1'b1;
      end else if (hold) begin
        hold = 1'b0;
      end else begin
        fifo_smatch = 1'($urandom_range(0, 1));
      end
      case (wr_mode)
        1: fifo_wready = 1'b1;
        2: fifo_wready = 1'b0;
        3: begin
          if (fifo_wvalid) begin
            fifo_wready = (lowc >= 5);
            lowc++;
          end else begin
            fifo_wready = 1'b0;
            lowc = 0;
          end
        end
        default: fifo_wready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rstn && fifo_wvalid && fifo_wready) rsp_fifo.push_back(fifo_wdata);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT acknowledges.
  initial begin
    int s_cyc;
    int wv_n;
    bit prev_sv;
    exp_t e;
    logic [NREQ-1:0] ex_rdy;
    s_cyc = 0;
    wv_n = 0;
    prev_sv = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        wv_n = 0;
        prev_sv = 1'b0;
      end else begin
        chk("dup_cnt", dup_cnt, mon_dup_exp);
        chk("ready_onehot", $countones(req_ready) <= 1, 1);
        chk("dup_without_ready", req_dup & ~req_ready, 0);
        if (!busy) chk("idle_quiet", {fifo_svalid, fifo_wvalid, req_ready}, 0);
        if (fifo_svalid) begin
          chk("svalid_one_cycle", prev_sv, 0);
          s_cyc = cyc;
          wv_n = 0;
          if (exp_q.size() == 0) chk("snoop_expected", 0, 1);
          else chk("sdata", fifo_sdata, exp_q[0].data);
        end
        if (fifo_wvalid) begin
          wv_n++;
          if (exp_q.size() != 0) begin
            chk("wdata", fifo_wdata, exp_q[0].data);
            chk("write_on_dup", exp_q[0].dup, 0);
          end
          chk("ack_on_wready", |req_ready, fifo_wready);
        end
        if (|req_ready) begin
          if (exp_q.size() == 0) begin
            chk("ack_expected", 0, 1);
          end else begin
            e = exp_q.pop_front();
            ex_rdy = NREQ'(1) << e.idx;
            chk("req_ready", req_ready, ex_rdy);
            chk("req_dup", req_dup, e.dup ? ex_rdy : '0);
            chk("ack_latency", cyc - s_cyc, e.dup ? 1 : 1 + wv_n);
            if (e.dup) chk("dup_no_write", wv_n, 0);
            if (e.dup && mon_dup_exp != 16'hFFFF) mon_dup_exp++;
            ack_cyc_q.push_back(cyc);
            $display("ack req=%0d dup=%0d data=%0h cycle=%0d", e.idx, e.dup, e.data, cyc);
          end
        end
        prev_sv = fifo_svalid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] pool [12];
    logic [127:0]  wide;
    int            wcount;
    int            nacks;
    int            nr;
    bit            seen;

    rstn        = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    model_last  = NREQ - 1;
    mon_dup_exp = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend_head[i] = 0;
      pend_cnt[i]  = 0;
    end
    pool[0] = DW'(5);
    for (int k = 1; k < 12; k++) begin
      wide    = {$urandom, $urandom, $urandom, $urandom};
      pool[k] = wide[DW-1:0];
    end

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_svalid", fifo_svalid, 0);
    chk("rst_wvalid", fifo_wvalid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_dup", req_dup, 0);
    chk("rst_dup_cnt", dup_cnt, 0);
    chk("rst_sdata", fifo_sdata, 0);
    chk("rst_wdata", fifo_wdata, 0);
    rstn   = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Single request with fixed latency; requester withdraws and changes data after grant.
    wr_mode = 1;
    pend_push(2, DW'(5));
    start_round();
    @(negedge clk);
    chk("t1_svalid", fifo_svalid, 1);
    chk("t1_sdata", fifo_sdata, 5);
    req_valid[2] = 1'b0;
    req_data[2*DW +: DW] = pool[3];
    @(negedge clk);
    chk("t1_wait_quiet", {fifo_svalid, fifo_wvalid, req_ready}, 0);
    @(negedge clk);
    chk("t1_wvalid", fifo_wvalid, 1);
    chk("t1_wdata", fifo_wdata, 5);
    chk("t1_ack", req_ready, 4'b0100);
    chk("t1_nodup", req_dup, 0);
    wait_idle("t1");

    // Duplicate of an already-written word.
    pend_push(1, DW'(5));
    start_round();
    @(negedge clk);
    chk("t2_cnt_before", dup_cnt, 0);
    @(negedge clk);
    chk("t2_ack", req_ready, 4'b0010);
    chk("t2_dup", req_dup, 4'b0010);
    chk("t2_no_wvalid", fifo_wvalid, 0);
    wait_idle("t2");
    chk("t2_cnt_after", dup_cnt, 1);

    // Write backpressure: five cycles of wready low.
    wr_mode = 3;
    pend_push(3, mk_uniq(1));
    start_round();
    wcount = 0;
    nacks  = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fifo_wvalid) wcount++;
      if (|req_ready) nacks++;
    end
    chk("bp_wvalid_cycles", wcount, 6);
    chk("bp_acks", nacks, 1);
    wait_idle("bp");

    // Fairness: all requesters continuously valid.
    wr_mode = 1;
    for (int i = 0; i < NREQ; i++) begin
      pend_push(i, mk_uniq(10 + i));
      pend_push(i, mk_uniq(20 + i));
    end
    ack_cyc_q.delete();
    start_round();
    wait_idle("fair");
    chk("fair_acks", ack_cyc_q.size(), 2 * NREQ);
    for (int k = 1; k < ack_cyc_q.size(); k++) chk("fair_spacing", ack_cyc_q[k] - ack_cyc_q[k-1], 4);

    // Random rounds with random write backpressure and smatch noise.
    wr_mode = 0;
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        nr = $urandom_range(0, 3);
        for (int j = 0; j < nr; j++) pend_push(i, pool[$urandom_range(0, 11)]);
      end
      if (pend_total() == 0) pend_push($urandom_range(0, NREQ - 1), pool[$urandom_range(0, 11)]);
      start_round();
      wait_idle("rand");
    end

    // Reset asserted while a write is stalled.
    mon_en  = 1'b0;
    wr_mode = 2;
    req_data[1*DW +: DW] = mk_uniq(99);
    req_valid[1] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = fifo_wvalid;
    end
    chk("rst_reach_write", seen, 1);
    rstn = 1'b0;
    #1;
    chk("rstw_wvalid", fifo_wvalid, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_ready", req_ready, 0);
    chk("rstw_dup_cnt", dup_cnt, 0);
    chk("rstw_sdata", fifo_sdata, 0);
    req_valid   = '0;
    model_last  = NREQ - 1;
    mon_dup_exp = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn    = 1'b1;
    mon_en  = 1'b1;
    wr_mode = 1;
    pend_push(3, mk_uniq(31));
    pend_push(0, mk_uniq(30));
    start_round();
    wait_idle("post_rst");

    // Saturation of the duplicate counter.
    mon_en = 1'b0;
    @(negedge clk);
    force dut.r_dup_cnt = 16'hFFFD;
    #1;
    release dut.r_dup_cnt;
    chk("sat_preload", dup_cnt, 16'hFFFD);
    mon_dup_exp = 16'hFFFD;
    mon_en = 1'b1;
    for (int i = 0; i < NREQ; i++) pend_push(i, DW'(5));
    start_round();
    wait_idle("sat");
    chk("sat_hold", dup_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
